// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants, FSM encoding and types for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // Default first fetch address and default bubble instruction
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INST_DEFAULT = 32'h0000_0000;

    // Fetch FSM encoding
    localparam int          c_STATE_W = 2;
    localparam logic [1:0]  c_ST_RUN  = 2'd0;  // request outstanding at pc
    localparam logic [1:0]  c_ST_FULL = 2'd1;  // skid entry occupied, no request
    localparam logic [1:0]  c_ST_DROP = 2'd2;  // stale request, its data is discarded

    // One fetched instruction with its address
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Instruction memory request/ack bus between fetch and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    // Fetch side issues requests
    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    // Memory side answers them
    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );

endinterface
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load, bubble and hold controls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = c_NOP_INST_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load,      // capture a real instruction
    input  wire logic        bubble,    // insert NOP, valid=0
    input  wire logic [31:0] pc_i,
    input  wire logic [31:0] inst_i,
    output logic [31:0]      id_pc_o,
    output logic [31:0]      id_inst_o,
    output logic             id_valid_o
);

    // Load beats bubble; with neither asserted the register holds
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_o    <= 32'h0000_0000;
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
        end else if (load) begin
            id_pc_o    <= pc_i;
            id_inst_o  <= inst_i;
            id_valid_o <= 1'b1;
        end else if (bubble) begin
            id_pc_o    <= pc_i;
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage with one-entry skid buffer for
//               stalls and stale-request dropping on redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = c_NOP_INST_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall_i,
    input  wire logic        branch_flag_i,
    input  wire logic [31:0] branch_target_address_i,
    if_stage_if.master       imem,
    output logic [31:0]      id_pc_o,
    output logic [31:0]      id_inst_o,
    output logic             id_valid_o
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [31:0]          r_pc;
    logic [31:0]          r_redir_pc;
    fetch_entry_t         r_skid;

    logic                 w_redirect;
    logic [31:0]          w_target;
    logic [31:0]          w_pc_inc;
    logic                 w_ack;

    logic                 w_pc_load;
    logic [31:0]          w_pc_next;
    logic                 w_redir_load;
    logic                 w_skid_load;
    logic                 w_id_load;
    logic                 w_id_bubble;
    logic [31:0]          w_id_pc;
    logic [31:0]          w_id_inst;

    // A stalled decode cannot accept a redirect, so it waits
    assign w_redirect = branch_flag_i & ~stall_i;
    assign w_target   = word_align(branch_target_address_i);
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_ack      = imem.imem_ack_i;

    // No request in FULL, and none while reset is held
    assign imem.imem_req_o  = ~rst & (r_state != c_ST_FULL);
    assign imem.imem_addr_o = r_pc;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_RUN;
        else     r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (w_redirect)          w_state_next = w_ack ? c_ST_RUN : c_ST_DROP;
                else if (stall_i && w_ack) w_state_next = c_ST_FULL;
                else                     w_state_next = c_ST_RUN;
            end
            c_ST_FULL: begin
                if (w_redirect || !stall_i) w_state_next = c_ST_RUN;
            end
            c_ST_DROP: begin
                if (w_ack) w_state_next = c_ST_RUN;
            end
            default: w_state_next = c_ST_RUN;
        endcase
    end

    // FSM output decode: pc/redir/skid updates and IF/ID controls
    always_comb begin
        w_pc_load    = 1'b0;
        w_pc_next    = w_pc_inc;
        w_redir_load = 1'b0;
        w_skid_load  = 1'b0;
        w_id_load    = 1'b0;
        w_id_bubble  = 1'b0;
        w_id_pc      = r_pc;
        w_id_inst    = imem.imem_rdata_i;
        case (r_state)
            c_ST_RUN: begin
                if (w_redirect) begin
                    // Any data returning this cycle belongs to the wrong path
                    w_id_bubble = 1'b1;
                    if (w_ack) begin
                        w_pc_load = 1'b1;
                        w_pc_next = w_target;
                    end else begin
                        w_redir_load = 1'b1;
                    end
                end else if (stall_i) begin
                    if (w_ack) begin
                        w_skid_load = 1'b1;
                        w_pc_load   = 1'b1;
                    end
                end else if (w_ack) begin
                    w_id_load = 1'b1;
                    w_pc_load = 1'b1;
                end else begin
                    w_id_bubble = 1'b1;
                end
            end
            c_ST_FULL: begin
                if (w_redirect) begin
                    w_id_bubble = 1'b1;
                    w_pc_load   = 1'b1;
                    w_pc_next   = w_target;
                end else if (!stall_i) begin
                    w_id_load = 1'b1;
                    w_id_pc   = r_skid.pc;
                    w_id_inst = r_skid.inst;
                end
            end
            c_ST_DROP: begin
                if (w_redirect)   w_redir_load = 1'b1;
                if (!stall_i)     w_id_bubble  = 1'b1;
                if (w_ack) begin
                    // A redirect arriving with the ack wins over the stored one
                    w_pc_load = 1'b1;
                    w_pc_next = w_redirect ? w_target : r_redir_pc;
                end
            end
            default: ;
        endcase
    end

    // Fetch address, pending redirect target and skid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_redir_pc <= RESET_PC;
            r_skid     <= '0;
        end else begin
            if (w_pc_load)    r_pc       <= w_pc_next;
            if (w_redir_load) r_redir_pc <= w_target;
            if (w_skid_load)  r_skid     <= '{pc: r_pc, inst: imem.imem_rdata_i};
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (w_id_load),
        .bubble     (w_id_bubble),
        .pc_i       (w_id_pc),
        .inst_i     (w_id_inst),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          lat;
    int          mem_cnt;

    if_stage_if bus();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (c_NOP)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_i                 (stall),
        .branch_flag_i           (branch_flag),
        .branch_target_address_i (branch_target),
        .imem                    (bus),
        .id_pc_o                 (id_pc),
        .id_inst_o               (id_inst),
        .id_valid_o              (id_valid)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is a fixed scramble of its address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory acks once a request has waited lat cycles; reset with the core
    assign bus.imem_ack_i   = bus.imem_req_o && (mem_cnt >= lat);
    assign bus.imem_rdata_i = word_at(bus.imem_addr_o);

    always @(posedge clk) begin
        if (rst || !bus.imem_req_o || bus.imem_ack_i) mem_cnt <= 0;
        else                                          mem_cnt <= mem_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = '0; lat = 0;
        tick; tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = '0; lat = 0;
        tick; tick;
        n_compared++; if (bus.imem_req_o !== 1'b0) begin n_mismatched++; $display("FAIL rst_req: got %0b want 0", bus.imem_req_o); end
        n_compared++; if (id_valid !== 1'b0) begin n_mismatched++; $display("FAIL rst_valid: got %0b want 0", id_valid); end
        n_compared++; if (id_inst !== c_NOP) begin n_mismatched++; $display("FAIL rst_inst: got %h want %h", id_inst, c_NOP); end
        n_compared++; if (id_pc !== 32'h0) begin n_mismatched++; $display("FAIL rst_pc: got %h want 0", id_pc); end
        rst = 1'b0;
        #1;
        n_compared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin n_mismatched++; $display("FAIL rst_first: got req=%0b addr=%h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_zero_wait;
        reset_dut;
        for (int k = 1; k <= 5; k++) begin
            tick;
            n_compared++; if (bus.imem_addr_o !== 32'(4 * k)) begin n_mismatched++; $display("FAIL zw_addr%0d: got %h want %h", k, bus.imem_addr_o, 32'(4 * k)); end
            n_compared++; if (id_pc !== 32'(4 * (k - 1)) || id_valid !== 1'b1) begin n_mismatched++; $display("FAIL zw_id%0d: got pc=%h v=%0b want pc=%h v=1", k, id_pc, id_valid, 32'(4 * (k - 1))); end
            n_compared++; if (id_inst !== word_at(32'(4 * (k - 1)))) begin n_mismatched++; $display("FAIL zw_inst%0d: got %h want %h", k, id_inst, word_at(32'(4 * (k - 1)))); end
        end
    endtask

    task automatic test_stall_skid;
        reset_dut;
        tick; tick; tick; tick;
        stall = 1'b1;
        n_compared++; if (bus.imem_addr_o !== 32'h10) begin n_mismatched++; $display("FAIL sk_addr: got %h want 10", bus.imem_addr_o); end
        tick;
        n_compared++; if (bus.imem_req_o !== 1'b0) begin n_mismatched++; $display("FAIL sk_req1: got %0b want 0", bus.imem_req_o); end
        n_compared++; if (id_pc !== 32'hC || id_valid !== 1'b1) begin n_mismatched++; $display("FAIL sk_hold: got pc=%h v=%0b want pc=c v=1", id_pc, id_valid); end
        tick; tick;
        stall = 1'b0;
        #1;
        n_compared++; if (bus.imem_req_o !== 1'b0) begin n_mismatched++; $display("FAIL sk_req3: got %0b want 0", bus.imem_req_o); end
        tick;
        n_compared++; if (id_pc !== 32'h10 || id_inst !== word_at(32'h10) || id_valid !== 1'b1) begin n_mismatched++; $display("FAIL sk_release: got pc=%h inst=%h v=%0b want pc=10 inst=%h v=1", id_pc, id_inst, id_valid, word_at(32'h10)); end
        n_compared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h14) begin n_mismatched++; $display("FAIL sk_resume: got req=%0b addr=%h want req=1 addr=14", bus.imem_req_o, bus.imem_addr_o); end
        tick;
        n_compared++; if (id_pc !== 32'h14 || id_inst !== word_at(32'h14)) begin n_mismatched++; $display("FAIL sk_next: got pc=%h inst=%h want pc=14", id_pc, id_inst); end
    endtask

    task automatic test_branch_same_cycle;
        reset_dut;
        tick; tick;
        branch_flag = 1'b1; branch_target = 32'h40;
        tick;
        branch_flag = 1'b0;
        n_compared++; if (id_valid !== 1'b0 || id_inst !== c_NOP) begin n_mismatched++; $display("FAIL br_bubble: got v=%0b inst=%h want v=0 inst=%h", id_valid, id_inst, c_NOP); end
        n_compared++; if (bus.imem_addr_o !== 32'h40) begin n_mismatched++; $display("FAIL br_addr: got %h want 40", bus.imem_addr_o); end
        tick;
        n_compared++; if (id_pc !== 32'h40 || id_valid !== 1'b1 || id_inst !== word_at(32'h40)) begin n_mismatched++; $display("FAIL br_target: got pc=%h v=%0b inst=%h want pc=40 v=1", id_pc, id_valid, id_inst); end
    endtask

    task automatic test_drop_latency;
        reset_dut;
        for (int k = 0; k < 8; k++) tick;
        lat = 2;
        #1;
        n_compared++; if (bus.imem_addr_o !== 32'h20 || bus.imem_ack_i !== 1'b0) begin n_mismatched++; $display("FAIL dr_start: got addr=%h ack=%0b want addr=20 ack=0", bus.imem_addr_o, bus.imem_ack_i); end
        tick;
        n_compared++; if (bus.imem_addr_o !== 32'h20 || id_valid !== 1'b0) begin n_mismatched++; $display("FAIL dr_wait: got addr=%h v=%0b want addr=20 v=0", bus.imem_addr_o, id_valid); end
        branch_flag = 1'b1; branch_target = 32'h82;
        tick;
        branch_flag = 1'b0;
        n_compared++; if (bus.imem_addr_o !== 32'h20 || bus.imem_req_o !== 1'b1) begin n_mismatched++; $display("FAIL dr_held: got addr=%h req=%0b want addr=20 req=1", bus.imem_addr_o, bus.imem_req_o); end
        tick;
        n_compared++; if (bus.imem_addr_o !== 32'h80 || id_valid !== 1'b0) begin n_mismatched++; $display("FAIL dr_redir: got addr=%h v=%0b want addr=80 v=0", bus.imem_addr_o, id_valid); end
        tick; tick;
        n_compared++; if (bus.imem_addr_o !== 32'h80 || id_valid !== 1'b0) begin n_mismatched++; $display("FAIL dr_wait80: got addr=%h v=%0b want addr=80 v=0", bus.imem_addr_o, id_valid); end
        tick;
        n_compared++; if (id_pc !== 32'h80 || id_valid !== 1'b1 || id_inst !== word_at(32'h80)) begin n_mismatched++; $display("FAIL dr_land: got pc=%h v=%0b inst=%h want pc=80 v=1", id_pc, id_valid, id_inst); end
        n_compared++; if (bus.imem_addr_o !== 32'h84) begin n_mismatched++; $display("FAIL dr_next: got %h want 84", bus.imem_addr_o); end
    endtask

    task automatic test_reset_in_full;
        reset_dut;
        tick; tick;
        stall = 1'b1;
        tick;
        n_compared++; if (bus.imem_req_o !== 1'b0) begin n_mismatched++; $display("FAIL rf_full: got req=%0b want 0", bus.imem_req_o); end
        rst = 1'b1;
        tick;
        n_compared++; if (id_pc !== 32'h0 || id_inst !== c_NOP || id_valid !== 1'b0 || bus.imem_req_o !== 1'b0) begin n_mismatched++; $display("FAIL rf_reset: got pc=%h inst=%h v=%0b req=%0b want 0/%h/0/0", id_pc, id_inst, id_valid, bus.imem_req_o, c_NOP); end
        stall = 1'b0; rst = 1'b0;
        #1;
        n_compared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin n_mismatched++; $display("FAIL rf_first: got req=%0b addr=%h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_reset_in_drop;
        reset_dut;
        tick; tick; tick;
        lat = 2; branch_flag = 1'b1; branch_target = 32'h100;
        tick;
        branch_flag = 1'b0;
        n_compared++; if (bus.imem_addr_o !== 32'hC || bus.imem_req_o !== 1'b1) begin n_mismatched++; $display("FAIL rd_drop: got addr=%h req=%0b want addr=c req=1", bus.imem_addr_o, bus.imem_req_o); end
        rst = 1'b1;
        tick;
        n_compared++; if (id_pc !== 32'h0 || id_inst !== c_NOP || id_valid !== 1'b0 || bus.imem_req_o !== 1'b0) begin n_mismatched++; $display("FAIL rd_reset: got pc=%h inst=%h v=%0b req=%0b want 0/%h/0/0", id_pc, id_inst, id_valid, bus.imem_req_o, c_NOP); end
        rst = 1'b0;
        #1;
        n_compared++; if (bus.imem_addr_o !== 32'h0 || bus.imem_req_o !== 1'b1) begin n_mismatched++; $display("FAIL rd_first: got addr=%h req=%0b want addr=0 req=1", bus.imem_addr_o, bus.imem_req_o); end
        tick; tick;
        n_compared++; if (id_valid !== 1'b0) begin n_mismatched++; $display("FAIL rd_wait: got v=%0b want 0", id_valid); end
        tick;
        n_compared++; if (id_pc !== 32'h0 || id_valid !== 1'b1 || id_inst !== word_at(32'h0)) begin n_mismatched++; $display("FAIL rd_land: got pc=%h v=%0b inst=%h want pc=0 v=1", id_pc, id_valid, id_inst); end
    endtask

    task automatic test_wrap;
        reset_dut;
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick;
        branch_flag = 1'b0;
        n_compared++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_mismatched++; $display("FAIL wr_align: got %h want fffffffc", bus.imem_addr_o); end
        tick;
        n_compared++; if (bus.imem_addr_o !== 32'h0) begin n_mismatched++; $display("FAIL wr_wrap: got %h want 0", bus.imem_addr_o); end
        n_compared++; if (id_pc !== 32'hFFFF_FFFC || id_valid !== 1'b1) begin n_mismatched++; $display("FAIL wr_id: got pc=%h v=%0b want pc=fffffffc v=1", id_pc, id_valid); end
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_stall_skid;
        test_branch_same_cycle;
        test_drop_latency;
        test_reset_in_full;
        test_reset_in_drop;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
